glitch_sweep: RTL and testbench
===============================

# glitch_sweep

Wishbone master that sequences the `glitch_wb` peripheral through a two-dimensional sweep of glitch delay and width. For each point it:

- loads one queue entry (mode, width, delay, pad);
- arms the glitcher via `GLITCH_STATUS`;
- polls until the glitcher reports ready;
- advances to the next point.

It sits between the host/control logic and the `glitch_wb` slave port, so unattended parameter searches need no per-shot host traffic.

## Interface
- `POLL_GAP`, 4: idle cycles between consecutive status polls (≥1).
- `TIMEOUT`, 1024: polls allowed per shot before error (used only with `GLITCH_SWEEP_TIMEOUT_EN`).
- `clk_i`  in  1  system clock; sole clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches configuration and begins sweep when idle.
- `abort`  in  1  one-cycle pulse; stops sweep after any in-flight bus cycle completes.
- `mode`  in  8  value written to `GLITCH_QUEUE_0` (e.g. `GLITCH_MODE_CLKGL`).
- `delay_first`, `delay_last`, `delay_step`  in  8 each  outer-axis range, inclusive.
- `width_first`, `width_last`, `width_step`  in  8 each  inner-axis range, inclusive.
- `adr_o`  out  [5:2]  Wishbone address.
- `dat_o`  out  8  Wishbone write data.
- `dat_i`  in  8  Wishbone read data.
- `we_o`  out  1  Wishbone write enable.
- `stb_o`  out  1  Wishbone strobe.
- `ack_i`  in  1  Wishbone acknowledge.
- `busy`  out  1  high from the cycle after `start` until return to IDLE.
- `done`  out  1  one-cycle pulse when the sweep ends (normal, abort or error).
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `cur_delay`, `cur_width`  out  8 each  parameters of the shot in progress or last shot.
- `shot_count`  out  16  shots armed since last `start`; saturates at 0xFFFF.

## Operation
- On `start` in IDLE:
  - latch all configuration inputs;
  - `cur_delay`←`delay_first`, `cur_width`←`width_first`;
  - clear `shot_count` and `err`.
- `start` while busy is ignored.
- A step of 0 is treated as 1.
- If first > last on an axis, that axis yields only the first value.
- States and transitions:
  - IDLE → WR_MODE: write `mode` to `GLITCH_QUEUE_0`.
  - WR_MODE → WR_WIDTH: write `cur_width` to `GLITCH_QUEUE_1`.
  - WR_WIDTH → WR_DELAY: write `cur_delay` to `GLITCH_QUEUE_2`.
  - WR_DELAY → WR_PAD: write 0x00 to `GLITCH_QUEUE_3`.
  - WR_PAD → ARM: write 0x01 to `GLITCH_STATUS`; `shot_count`++.
  - ARM → GAP.
  - GAP: wait `POLL_GAP` cycles → POLL.
  - POLL: read `GLITCH_STATUS`. If `dat_i[0]`=1 → NEXT, else → GAP.
  - NEXT: advance width (computed 9-bit; next = `cur_width`+step).
    - If next ≤ `width_last` with no carry: `cur_width`←next → WR_MODE.
    - Otherwise `cur_width`←`width_first`, advance delay by the same rule.
    - Delay exhausted → DONE.
  - DONE: pulse `done` → IDLE.
- Each address of the sequence is written once per shot, in the order above.
- `abort` is sampled and held pending; it is honoured at the next bus-idle state boundary → DONE, with no further writes.

## Timing
- Bus cycle:
  - `stb_o`, `we_o`, `adr_o`, `dat_o` are registered.
  - `stb_o` stays high until the cycle in which `ack_i`=1 is sampled, then drops for at least one cycle before the next strobe.
  - No wait limit on `ack_i`.
- Read data is captured in the `ack_i` cycle.
- Reset values: `stb_o`=0, `we_o`=0, `adr_o`=0, `dat_o`=0x00, `busy`=0, `done`=0, `err`=0, `cur_delay`=0, `cur_width`=0, `shot_count`=0; state IDLE.
- Reset mid-bus-cycle drops `stb_o` the next edge.
- `start` and `abort` in the same cycle while idle: `start` is accepted, then the sweep aborts before the first write.
- Wrap-around: last=0xFF with step 1 ends after 0xFF (the carry terminates the axis; no repeat of 0x00).

## Configuration
- `GLITCH_SWEEP_TIMEOUT_EN` defined:
  - POLL counts polls per shot;
  - on reaching `TIMEOUT` without ready: set `err`, → DONE.
- Not defined: polling continues indefinitely; `err` is tied 0; `TIMEOUT` is unused.

## Test plan
- Single point: mode=0x08, delay 2..2, width 3..3 → writes Q0=0x08, Q1=0x03, Q2=0x02, Q3=0x00, STATUS=0x01, in order; polls until ready; one `done`; `shot_count`=1.
- Grid: delay 0..3 step 3, width 0..5 step 5 → shots (d,w) = (0,0),(0,5),(3,0),(3,5); `shot_count`=4.
- Boundaries: width 0xFE..0xFF step 0 → widths 0xFE, 0xFF only, then `done`; delay first=5 last=2 → single delay 5.
- Slave inserts 3 wait cycles before each `ack_i` → `stb_o` held high for 4 cycles per access; sequence unchanged.
- `abort` during POLL of shot 2 of 4 → `done` after the poll completes, no further writes, `shot_count`=2, `busy` falls.
- With `GLITCH_SWEEP_TIMEOUT_EN`, `TIMEOUT`=8, status stuck at 0 → 8 polls, then `err`=1 and `done`; the next `start` clears `err`.

Source files
------------

// File: rtl/glitch_sweep_if.sv
// Wishbone link between glitch_sweep (master) and the glitch_wb slave port.
// adr_o keeps the slave's word-address range [5:2].
interface glitch_sweep_if;
  logic [5:2] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       we_o;
  logic       stb_o;
  logic       ack_i;

  modport master (output adr_o, dat_o, we_o, stb_o, input dat_i, ack_i);
  modport slave  (input adr_o, dat_o, we_o, stb_o, output dat_i, ack_i);
endinterface

// File: rtl/glitch_sweep.sv
// glitch_sweep: Wishbone master stepping glitch_wb through a delay x width grid.
// Define GLITCH_SWEEP_TIMEOUT_EN to abort a shot with err after TIMEOUT unready polls.
module glitch_sweep #(
  parameter int         POLL_GAP   = 4,
  parameter int         TIMEOUT    = 1024,
  parameter logic [3:0] ADR_STATUS = 4'h0,
  parameter logic [3:0] ADR_Q0     = 4'h4,
  parameter logic [3:0] ADR_Q1     = 4'h5,
  parameter logic [3:0] ADR_Q2     = 4'h6,
  parameter logic [3:0] ADR_Q3     = 4'h7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  glitch_sweep_if.master        wb,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            mode,
  input  logic [7:0]            delay_first,
  input  logic [7:0]            delay_last,
  input  logic [7:0]            delay_step,
  input  logic [7:0]            width_first,
  input  logic [7:0]            width_last,
  input  logic [7:0]            width_step,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            cur_delay,
  output logic [7:0]            cur_width,
  output logic [15:0]           shot_count
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_MODE, ST_WR_WIDTH, ST_WR_DELAY, ST_WR_PAD,
    ST_ARM, ST_GAP, ST_POLL, ST_NEXT, ST_DONE
  } state_t;

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  state_t        state;
  logic [7:0]    cfg_mode, d_first, d_last, d_step, w_first, w_last, w_step;
  logic [GW-1:0] gap_cnt;
  logic          abort_pend, ab;
  logic [3:0]    req_adr;
  logic [7:0]    req_dat;
  logic          req_we;
  logic [8:0]    w_nxt, d_nxt;
  logic          w_ok, d_ok;

`ifdef GLITCH_SWEEP_TIMEOUT_EN
  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] TO_LAST = PW'(TIMEOUT - 1);
  logic [PW-1:0] poll_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ab = abort_pend | abort;

  // 9-bit sums: a carry out of 0xFF ends the axis instead of wrapping to 0x00
  assign w_nxt = {1'b0, cur_width} + {1'b0, w_step};
  assign d_nxt = {1'b0, cur_delay} + {1'b0, d_step};
  assign w_ok  = !w_nxt[8] && (w_nxt[7:0] <= w_last);
  assign d_ok  = !d_nxt[8] && (d_nxt[7:0] <= d_last);

  always_comb begin
    req_adr = ADR_STATUS;
    req_dat = 8'h00;
    req_we  = 1'b1;
    case (state)
      ST_WR_MODE:  begin req_adr = ADR_Q0; req_dat = cfg_mode;  end
      ST_WR_WIDTH: begin req_adr = ADR_Q1; req_dat = cur_width; end
      ST_WR_DELAY: begin req_adr = ADR_Q2; req_dat = cur_delay; end
      ST_WR_PAD:   begin req_adr = ADR_Q3; req_dat = 8'h00;     end
      ST_ARM:      begin req_adr = ADR_STATUS; req_dat = 8'h01; end
      ST_POLL:     req_we = 1'b0;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      wb.stb_o   <= 1'b0;
      wb.we_o    <= 1'b0;
      wb.adr_o   <= 4'h0;
      wb.dat_o   <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_delay  <= 8'h00;
      cur_width  <= 8'h00;
      shot_count <= 16'h0000;
      abort_pend <= 1'b0;
      gap_cnt    <= '0;
      cfg_mode   <= 8'h00;
      d_first    <= 8'h00;
      d_last     <= 8'h00;
      d_step     <= 8'h01;
      w_first    <= 8'h00;
      w_last     <= 8'h00;
      w_step     <= 8'h01;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
      poll_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort && (state != ST_IDLE || start)) abort_pend <= 1'b1;

      case (state)
        ST_IDLE: if (start) begin
          cfg_mode   <= mode;
          d_first    <= delay_first;
          d_last     <= delay_last;
          d_step     <= (delay_step == 8'h00) ? 8'h01 : delay_step;
          w_first    <= width_first;
          w_last     <= width_last;
          w_step     <= (width_step == 8'h00) ? 8'h01 : width_step;
          cur_delay  <= delay_first;
          cur_width  <= width_first;
          shot_count <= 16'h0000;
          busy       <= 1'b1;
          state      <= ST_WR_MODE;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
          err_q      <= 1'b0;
`endif
        end

        // Bus states: raise strobe on entry, advance on ack; abort only between cycles
        ST_WR_MODE, ST_WR_WIDTH, ST_WR_DELAY, ST_WR_PAD, ST_ARM, ST_POLL: begin
          if (wb.stb_o) begin
            if (wb.ack_i) begin
              wb.stb_o <= 1'b0;
              case (state)
                ST_WR_MODE:  state <= ST_WR_WIDTH;
                ST_WR_WIDTH: state <= ST_WR_DELAY;
                ST_WR_DELAY: state <= ST_WR_PAD;
                ST_WR_PAD:   state <= ST_ARM;
                ST_ARM: begin
                  if (shot_count != 16'hFFFF) shot_count <= shot_count + 16'd1;
                  gap_cnt <= '0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
                  poll_cnt <= '0;
`endif
                  state   <= ST_GAP;
                end
                default: begin
                  if (wb.dat_i[0]) state <= ST_NEXT;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
                  else if (poll_cnt == TO_LAST) begin
                    err_q <= 1'b1;
                    state <= ST_DONE;
                  end else begin
                    poll_cnt <= poll_cnt + PW'(1);
                    gap_cnt  <= '0;
                    state    <= ST_GAP;
                  end
`else
                  else begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                  end
`endif
                end
              endcase
            end
          end else if (ab) begin
            state <= ST_DONE;
          end else begin
            wb.stb_o <= 1'b1;
            wb.we_o  <= req_we;
            wb.adr_o <= req_adr;
            wb.dat_o <= req_dat;
          end
        end

        ST_GAP: begin
          if (ab) state <= ST_DONE;
          else if (gap_cnt == GAP_LAST) state <= ST_POLL;
          else gap_cnt <= gap_cnt + GW'(1);
        end

        ST_NEXT: begin
          if (ab) state <= ST_DONE;
          else if (w_ok) begin
            cur_width <= w_nxt[7:0];
            state     <= ST_WR_MODE;
          end else if (d_ok) begin
            cur_width <= w_first;
            cur_delay <= d_nxt[7:0];
            state     <= ST_WR_MODE;
          end else begin
            state <= ST_DONE;
          end
        end

        ST_DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          abort_pend <= 1'b0;
          state      <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_glitch_sweep.sv
// Directed bench for glitch_sweep: Wishbone slave model logs writes/polls,
// expected write streams are built from hand-listed (delay, width) shots.
module tb_glitch_sweep;
  localparam logic [3:0] A_ST = 4'h0, A_Q0 = 4'h4, A_Q1 = 4'h5, A_Q2 = 4'h6, A_Q3 = 4'h7;

  logic        tb_clk = 1'b0;
  logic        rst_i  = 1'b1;
  logic        start  = 1'b0, abort = 1'b0;
  logic [7:0]  mode = 8'h00;
  logic [7:0]  delay_first = 8'h00, delay_last = 8'h00, delay_step = 8'h00;
  logic [7:0]  width_first = 8'h00, width_last = 8'h00, width_step = 8'h00;
  logic        busy, done, err;
  logic [7:0]  cur_delay, cur_width;
  logic [15:0] shot_count;

  glitch_sweep_if bus();

  glitch_sweep #(.POLL_GAP(4), .TIMEOUT(8)) dut (
    .clk_i(tb_clk), .rst_i(rst_i), .wb(bus),
    .start(start), .abort(abort), .mode(mode),
    .delay_first(delay_first), .delay_last(delay_last), .delay_step(delay_step),
    .width_first(width_first), .width_last(width_last), .width_step(width_step),
    .busy(busy), .done(done), .err(err),
    .cur_delay(cur_delay), .cur_width(cur_width), .shot_count(shot_count)
  );

  always #5 tb_clk = ~tb_clk;

  int n_tests = 0, n_fail = 0;
  int wait_n = 0, ready_polls = 1;
  int wcnt = 0, hi = 0, polls_shot = 0, n_polls = 0, hold_bad = 0, stb_late = 0, ndone = 0;
  logic       acc_we;
  logic [3:0] acc_adr;
  logic [7:0] acc_dat;
  logic [11:0] wr_q[$];
  logic [11:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Slave: acks after wait_n wait cycles, status reads go ready on poll ready_polls
  initial begin bus.ack_i = 1'b0; bus.dat_i = 8'h00; end
  always @(posedge tb_clk) begin
    #1;
    if (bus.ack_i) begin
      bus.ack_i = 1'b0;
      if (bus.stb_o) stb_late++;
      if (hi != wait_n + 1) hold_bad++;
      if (acc_we) begin
        wr_q.push_back({acc_adr, acc_dat});
        if (acc_adr == A_ST) polls_shot = 0;
      end else n_polls++;
      hi = 0; wcnt = 0;
    end else if (bus.stb_o) begin
      hi++;
      if (wcnt == wait_n) begin
        bus.ack_i = 1'b1;
        acc_we = bus.we_o; acc_adr = bus.adr_o; acc_dat = bus.dat_o;
        if (!bus.we_o) begin
          polls_shot++;
          bus.dat_i = (ready_polls != 0 && polls_shot >= ready_polls) ? 8'h01 : 8'h00;
        end
      end else wcnt++;
    end else begin
      hi = 0; wcnt = 0;
    end
  end

  task automatic push_shot(input logic [7:0] md, input logic [7:0] d, input logic [7:0] w);
    exp_q.push_back({A_Q0, md});
    exp_q.push_back({A_Q1, w});
    exp_q.push_back({A_Q2, d});
    exp_q.push_back({A_Q3, 8'h00});
    exp_q.push_back({A_ST, 8'h01});
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    chk({tag, "_stb_gap"}, stb_late, 0);
    chk({tag, "_stb_hold"}, hold_bad, 0);
  endtask

  task automatic run(input string tag, input logic [7:0] md,
                     input logic [7:0] df, input logic [7:0] dl, input logic [7:0] ds,
                     input logic [7:0] wf, input logic [7:0] wl, input logic [7:0] ws,
                     input int rp, input int ab_shot, input bit ab_now);
    bit fin = 0, ab_sent = 0;
    wr_q.delete(); exp_q.delete();
    n_polls = 0; polls_shot = 0; hold_bad = 0; stb_late = 0; ndone = 0; ready_polls = rp;
    mode = md; delay_first = df; delay_last = dl; delay_step = ds;
    width_first = wf; width_last = wl; width_step = ws;
    @(posedge tb_clk); #2; start = 1'b1; abort = ab_now;
    @(posedge tb_clk); #2; start = 1'b0; abort = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(posedge tb_clk); #2;
      abort = 1'b0;
      if (done) begin ndone++; fin = 1; end
      else if (ab_shot != 0 && !ab_sent && shot_count == 16'(ab_shot) && bus.stb_o && !bus.we_o) begin
        abort = 1'b1; ab_sent = 1;
      end
    end
    chk({tag, "_done_seen"}, fin, 1);
    repeat (6) begin @(posedge tb_clk); #2; if (done) ndone++; end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge tb_clk);
    #2; rst_i = 1'b0;
    chk("rst_stb", bus.stb_o, 0);
    chk("rst_we", bus.we_o, 0);
    chk("rst_adr", bus.adr_o, 0);
    chk("rst_dat", bus.dat_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur", {cur_delay, cur_width}, 0);
    chk("rst_shots", shot_count, 0);

    // single point, status ready on third poll
    run("single", 8'h08, 8'h02, 8'h02, 8'h01, 8'h03, 8'h03, 8'h01, 3, 0, 0);
    push_shot(8'h08, 8'h02, 8'h03);
    check_writes("single");
    chk("single_polls", n_polls, 3);
    chk("single_shots", shot_count, 1);
    chk("single_cur", {cur_delay, cur_width}, 16'h0203);

    // 2x2 grid, ready on second poll
    run("grid", 8'h08, 8'h00, 8'h03, 8'h03, 8'h00, 8'h05, 8'h05, 2, 0, 0);
    push_shot(8'h08, 8'h00, 8'h00); push_shot(8'h08, 8'h00, 8'h05);
    push_shot(8'h08, 8'h03, 8'h00); push_shot(8'h08, 8'h03, 8'h05);
    check_writes("grid");
    chk("grid_polls", n_polls, 8);
    chk("grid_shots", shot_count, 4);
    chk("grid_cur", {cur_delay, cur_width}, 16'h0305);

    // step 0 acts as 1, width ends at 0xFF without wrapping, delay first>last
    run("bound", 8'h11, 8'h05, 8'h02, 8'h01, 8'hFE, 8'hFF, 8'h00, 1, 0, 0);
    push_shot(8'h11, 8'h05, 8'hFE); push_shot(8'h11, 8'h05, 8'hFF);
    check_writes("bound");
    chk("bound_shots", shot_count, 2);
    chk("bound_cur", {cur_delay, cur_width}, 16'h05FF);

    // three wait states per access
    wait_n = 3;
    run("wait", 8'h08, 8'h02, 8'h02, 8'h01, 8'h03, 8'h03, 8'h01, 1, 0, 0);
    push_shot(8'h08, 8'h02, 8'h03);
    check_writes("wait");
    chk("wait_shots", shot_count, 1);
    wait_n = 0;

    // abort during a poll of shot 2 of 4 (first poll not ready)
    run("abort", 8'h08, 8'h00, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 2, 2, 0);
    push_shot(8'h08, 8'h00, 8'h00); push_shot(8'h08, 8'h00, 8'h01);
    check_writes("abort");
    chk("abort_shots", shot_count, 2);

    // start and abort together while idle: no writes at all
    run("stab", 8'h08, 8'h00, 8'h03, 8'h01, 8'h00, 8'h03, 8'h01, 1, 0, 1);
    check_writes("stab");
    chk("stab_shots", shot_count, 0);

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    run("tmo", 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 0, 0, 0);
    chk("tmo_polls", n_polls, 8);
    chk("tmo_err", err, 1);
    run("tmo_clr", 8'h08, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    chk("tmo_clr_err", err, 0);
`else
    chk("err_tied", err, 0);
`endif

    // reset in the middle of a stretched bus cycle
    wait_n = 3;
    @(posedge tb_clk); #2; start = 1'b1;
    @(posedge tb_clk); #2; start = 1'b0;
    for (int c = 0; c < 50 && !bus.stb_o; c++) begin @(posedge tb_clk); #2; end
    chk("mid_stb_seen", bus.stb_o, 1);
    rst_i = 1'b1;
    @(posedge tb_clk); #2;
    chk("mid_rst_stb", bus.stb_o, 0);
    chk("mid_rst_busy", busy, 0);
    rst_i = 1'b0;
    repeat (4) @(posedge tb_clk);
    #2;
    chk("mid_rst_idle", bus.stb_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
